// File: rtl/trdb_pkg.sv
// Shared definitions for the byte-packed trace stream.
//
// Stream format, LSB first, packets contiguous across bus words:
//   PACKET_BYTE_HEADER_LEN bits of N (payload byte count),
//   4 custom bits, 8*N payload bits, zero padding to a byte boundary.
// The aligner (transmit side) and the unaligner (receive side) both size
// packets through packet_bytes() so the two ends cannot disagree.
package trdb_pkg;

  localparam int unsigned BUS_DATA_WIDTH         = 32;
  localparam int unsigned PACKET_LEN             = 68;
  localparam int unsigned PACKET_BYTE_HEADER_LEN = 5;

  // Largest packet on the wire, in bytes, including header and padding.
  localparam int unsigned PACKET_MAX_BYTES = (PACKET_BYTE_HEADER_LEN + PACKET_LEN + 7) / 8;
  localparam int unsigned DATA_BYTES       = BUS_DATA_WIDTH / 8;
  // One full packet plus one incoming word, so a word can always land
  // behind a packet that is waiting for its last bytes.
  localparam int unsigned BUF_BYTES        = PACKET_MAX_BYTES + DATA_BYTES;

  // Bytes occupied on the wire by a packet with n payload bytes.
  function automatic int unsigned packet_bytes(input int unsigned hdr_len,
                                               input int unsigned n);
    return (hdr_len + 4 + 8 * n + 7) / 8;
  endfunction

  typedef enum logic [1:0] {
    HDR,
    BODY,
    ERR
  } unalign_state_e;

endpackage

// File: rtl/trdb_byte_fifo_shift.sv
// Byte-granular shift buffer.
//
// Byte 0 is always the oldest byte. Each cycle the caller may pop a
// variable number of bytes from the front and push a fixed-width word at
// the back; both happen in the same edge, with the push landing directly
// behind the bytes that survive the pop.
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        synchronous flush (empties the buffer)
//   push_i         append push_data_i this cycle
//   push_data_i    PUSH_BYTES bytes, byte 0 in bits [7:0]
//   pop_cnt_i      bytes removed from the front this cycle (<= fill_o)
//   data_o         whole buffer, byte i in bits [8*i +: 8]
//   fill_o         number of valid bytes held
module trdb_byte_fifo_shift #(
  parameter int unsigned DEPTH      = 14,
  parameter int unsigned PUSH_BYTES = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic [PUSH_BYTES*8-1:0] push_data_i,
  input  logic [CNT_W-1:0]        pop_cnt_i,
  output logic [DEPTH*8-1:0]      data_o,
  output logic [CNT_W-1:0]        fill_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic [CNT_W-1:0] keep;

  // Surviving bytes shift down by pop_cnt_i; the pushed word fills the
  // slots right after them; everything beyond is zeroed so stale bytes
  // never look like a header.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    keep   = fill_q - pop_cnt_i;
    fill_d = keep + (push_i ? CNT_W'(PUSH_BYTES) : '0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = '0;
      if (i < int'(keep)) begin
        mem_d[i] = mem_q[i + int'(pop_cnt_i)];
      end else if (push_i && ((i - int'(keep)) < PUSH_BYTES)) begin
        mem_d[i] = push_data_i[8*(i - int'(keep)) +: 8];
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q <= '0;
      // NOTE: the storage is reset too; it is only DEPTH bytes, and a known
      // zero content keeps data_o deterministic out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      fill_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) data_o[8*i +: 8] = mem_q[i];
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/trdb_stream_unalign8.sv
// Receive side of the byte-packed trace stream.
//
// Accepts BUS_DATA_WIDTH-bit words, recovers the byte-aligned packets they
// carry and presents one packet per valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   data_i/valid_i  incoming stream word, accepted when valid_i && ready_o
//   ready_o         room for one more word and no header error
//   clear_i         synchronous resync: drops buffer, output and error
//   packet_bits_o   {payload bytes, custom4}, LSB-aligned, upper bits zero
//   packet_len_o    4 + 8*N
//   valid_o/ready_i packet handshake
//   error_o         sticky: a header announced more than MAX_PAYLOAD_BYTES
module trdb_stream_unalign8
  import trdb_pkg::*;
#(
  parameter int unsigned ID                = 1,
  parameter int unsigned MAX_PAYLOAD_BYTES = (PACKET_LEN - 4) / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [BUS_DATA_WIDTH-1:0]     data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          clear_i,
  output logic [PACKET_LEN-1:0]         packet_bits_o,
  output logic [$clog2(PACKET_LEN)-1:0] packet_len_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          error_o
);

  localparam int unsigned H         = PACKET_BYTE_HEADER_LEN;
  localparam int unsigned HDR_BYTES = (H + 4 + 7) / 8;
  localparam int unsigned CNT_W     = $clog2(BUF_BYTES + 1);
  localparam int unsigned LEN_W     = $clog2(PACKET_LEN);
  localparam int unsigned BUF_W     = BUF_BYTES * 8;

  if (PACKET_BYTE_HEADER_LEN > 8) begin : g_hdr_len_chk
    $error("PACKET_BYTE_HEADER_LEN must be <= 8");
  end
  if (BUS_DATA_WIDTH % 8 != 0) begin : g_bus_width_chk
    $error("BUS_DATA_WIDTH must be a multiple of 8");
  end

  logic [BUF_W-1:0]      buf_data;
  logic [CNT_W-1:0]      fill;
  logic [CNT_W-1:0]      consumed;
  logic                  push;

  unalign_state_e        state_q, state_d;

  logic [H-1:0]          hdr_n, n_q, load_n;
  logic [CNT_W-1:0]      hdr_p, p_q;
  logic                  hdr_ready, hdr_fits, body_fits, out_free;
  logic                  load, latch_hdr, set_err;

  logic                  valid_q, error_q;
  logic [PACKET_LEN-1:0] bits_q, load_bits, len_mask;
  logic [LEN_W-1:0]      len_q, load_len;

  // Buffer bytes past the longest packet are never read as packet bits;
  // ID is reserved for multi-core tracing.
  logic                  unused_bits;
  assign unused_bits = ^{buf_data[BUF_W-1:H+PACKET_LEN], 1'(ID != 0)};

  trdb_byte_fifo_shift #(
    .DEPTH      (BUF_BYTES),
    .PUSH_BYTES (DATA_BYTES),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (push),
    .push_data_i (data_i),
    .pop_cnt_i   (consumed),
    .data_o      (buf_data),
    .fill_o      (fill)
  );

  // Room is judged on the registered fill only; bytes popped in the same
  // cycle are not credited, which keeps ready_o off the pop path.
  assign ready_o   = !error_q && (32'(fill) + DATA_BYTES <= BUF_BYTES);
  assign push      = valid_i && ready_o && !clear_i;

  assign hdr_n     = buf_data[H-1:0];
  assign hdr_p     = CNT_W'(packet_bytes(H, 32'(hdr_n)));
  assign hdr_ready = 32'(fill) >= HDR_BYTES;
  assign out_free  = !valid_q || ready_i;
  // A fully resident packet is emitted straight from HDR, so back-to-back
  // resident packets stream at one per cycle.
  assign hdr_fits  = (fill >= hdr_p) && out_free;
  assign body_fits = (fill >= p_q) && out_free;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= HDR;
    else if (clear_i) state_q <= HDR;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR: begin
        if (hdr_ready && (hdr_n != '0)) begin
          if (32'(hdr_n) > MAX_PAYLOAD_BYTES) state_d = ERR;
          else if (!hdr_fits)                 state_d = BODY;
        end
      end
      BODY:    if (body_fits) state_d = HDR;
      ERR:     state_d = ERR;
      default: state_d = HDR;
    endcase
  end

  always_comb begin
    consumed  = '0;
    load      = 1'b0;
    load_n    = '0;
    latch_hdr = 1'b0;
    set_err   = 1'b0;
    unique case (state_q)
      HDR: begin
        if (hdr_ready) begin
          if (hdr_n == '0) begin
            // Filler byte from a zero-filled flush tail.
            consumed = CNT_W'(1);
          end else if (32'(hdr_n) > MAX_PAYLOAD_BYTES) begin
            set_err = 1'b1;
          end else if (hdr_fits) begin
            load     = 1'b1;
            load_n   = hdr_n;
            consumed = hdr_p;
          end else begin
            latch_hdr = 1'b1;
          end
        end
      end
      BODY: begin
        if (body_fits) begin
          load     = 1'b1;
          load_n   = n_q;
          consumed = p_q;
        end
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------- output datapath
  // The header always sits at bit 0 of the buffer when a packet loads, so
  // the packet bits are a fixed slice masked down to 4+8N.
  always_comb begin
    load_len  = LEN_W'(32'd4 + 32'(load_n) * 32'd8);
    len_mask  = (PACKET_LEN'(1) << load_len) - PACKET_LEN'(1);
    load_bits = buf_data[H +: PACKET_LEN] & len_mask;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      bits_q  <= '0;
      len_q   <= '0;
      error_q <= 1'b0;
    end else if (clear_i) begin
      n_q     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      bits_q  <= '0;
      len_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (latch_hdr) begin
        n_q <= hdr_n;
        p_q <= hdr_p;
      end
      if (set_err) error_q <= 1'b1;
      if (load) begin
        valid_q <= 1'b1;
        bits_q  <= load_bits;
        len_q   <= load_len;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o       = valid_q;
  assign packet_bits_o = bits_q;
  assign packet_len_o  = len_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_trdb_stream_unalign8.sv
// Bench for trdb_stream_unalign8 (32-bit bus, 5-bit header, PACKET_LEN 68).
// Stimulus is built by an encoder that packs packets into a byte stream;
// every encoded packet is also queued as an expected output, and one
// compare process matches each handshake against that queue in order.
module tb_trdb_stream_unalign8;
  import trdb_pkg::*;

  localparam int H  = 5;
  localparam int PL = 68;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [31:0]   data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          clear_i = 1'b0;
  logic [PL-1:0] packet_bits_o;
  logic [LW-1:0] packet_len_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          error_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]    byte_q[$];
  logic [PL-1:0] exp_bits[$];
  logic [LW-1:0] exp_len[$];

  logic          held = 1'b0;
  logic [PL-1:0] held_bits;
  logic [LW-1:0] held_len;
  logic          saw_stall = 1'b0;

  trdb_stream_unalign8 dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .clear_i       (clear_i),
    .packet_bits_o (packet_bits_o),
    .packet_len_o  (packet_len_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encode one packet onto the byte stream; optionally expect it out.
  task automatic add_packet(input int n, input logic [3:0] custom, input logic [7:0] first,
                            input logic [7:0] step, input bit expect_it);
    logic [127:0] pb;
    logic [127:0] v;
    int           p;
    pb = 128'(custom);
    for (int i = 0; i < n; i++) pb |= 128'(8'(first + step * i)) << (4 + 8 * i);
    v = 128'(n) | (pb << H);
    p = (H + 4 + 8 * n + 7) / 8;
    for (int i = 0; i < p; i++) byte_q.push_back(v[8*i +: 8]);
    if (expect_it) begin
      exp_bits.push_back(pb[PL-1:0]);
      exp_len.push_back(LW'(4 + 8 * n));
    end
  endtask

  task automatic pop_word(output logic [31:0] w);
    w = '0;
    for (int i = 0; i < 4; i++) if (byte_q.size() > 0) w[8*i +: 8] = byte_q.pop_front();
  endtask

  // Present a word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    data_i  = w;
    valid_i = 1'b1;
    while (!ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_word timeout: ready_o stuck at %0b expected 1", ready_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic flush_words();
    logic [31:0] w;
    while (byte_q.size() > 0) begin
      pop_word(w);
      send_word(w);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_bits.size() != 0 || valid_o) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, " drained"}, 128'(exp_bits.size()), 128'(0));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: every handshake against the expected queue; every
  // stalled cycle against the previous cycle's output.
  always @(negedge clk) begin
    if (!rst_ni || clear_i) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold valid", 128'(valid_o), 128'(1));
        check("hold bits", 128'(packet_bits_o), 128'(held_bits));
        check("hold len", 128'(packet_len_o), 128'(held_len));
        held = 1'b0;
      end
      if (valid_o) begin
        if (ready_i) begin
          if (exp_bits.size() == 0) begin
            check("unexpected packet", 128'(packet_bits_o), 128'(0));
          end else begin
            check("packet bits", 128'(packet_bits_o), 128'(exp_bits.pop_front()));
            check("packet len", 128'(packet_len_o), 128'(exp_len.pop_front()));
          end
        end else begin
          held      = 1'b1;
          held_bits = packet_bits_o;
          held_len  = packet_len_o;
        end
      end
      if (valid_i && !ready_o) saw_stall = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;

    // Reset state
    #1;
    check("rst ready_o", 128'(ready_o), 128'(1));
    check("rst valid_o", 128'(valid_o), 128'(0));
    check("rst bits", 128'(packet_bits_o), 128'(0));
    check("rst len", 128'(packet_len_o), 128'(0));
    check("rst error_o", 128'(error_o), 128'(0));
    cycles(2);
    rst_ni = 1'b1;
    cycles(1);

    // 1. Single word, N=1, custom 0xA, payload 0x5C
    add_packet(1, 4'hA, 8'h5C, 8'h00, 1'b1);
    pop_word(w);
    check("encode word", 128'(w), 128'h0000B941);
    send_word(32'h0000B941);
    cycles(1);
    check("t1 valid", 128'(valid_o), 128'(1));
    check("t1 bits", 128'(packet_bits_o), 128'h5CA);
    check("t1 len", 128'(packet_len_o), 128'(12));
    cycles(1);
    check("t1 valid drops", 128'(valid_o), 128'(0));
    check("t1 error", 128'(error_o), 128'(0));
    wait_drain("t1");

    // 2. N=6 packet then N=1 packet across three words
    saw_stall = 1'b0;
    add_packet(6, 4'h3, 8'h11, 8'h11, 1'b1);
    add_packet(1, 4'hF, 8'hA5, 8'h00, 1'b1);
    flush_words();
    wait_drain("t2");
    check("t2 no backpressure", 128'(saw_stall), 128'(0));

    // 3. Output stalled for 10 cycles while words keep coming
    saw_stall = 1'b0;
    for (int k = 0; k < 10; k++) add_packet(1, 4'(k), 8'(k * 37 + 1), 8'h00, 1'b1);
    ready_i = 1'b0;
    fork
      flush_words();
      begin
        cycles(10);
        ready_i = 1'b1;
      end
    join
    wait_drain("t3");
    check("t3 ready_o dropped", 128'(saw_stall), 128'(1));

    // 4. Oversized header -> sticky error, then clear
    send_word(32'h00000009);
    cycles(4);
    check("t4 error_o", 128'(error_o), 128'(1));
    check("t4 ready_o", 128'(ready_o), 128'(0));
    check("t4 valid_o", 128'(valid_o), 128'(0));
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    check("t4 clr error_o", 128'(error_o), 128'(0));
    check("t4 clr ready_o", 128'(ready_o), 128'(1));
    check("t4 clr valid_o", 128'(valid_o), 128'(0));
    exp_bits.push_back(PL'(68'h5CA));
    exp_len.push_back(LW'(12));
    send_word(32'h0000B941);
    cycles(1);
    check("t4 valid", 128'(valid_o), 128'(1));
    check("t4 bits", 128'(packet_bits_o), 128'h5CA);
    check("t4 len", 128'(packet_len_o), 128'(12));
    wait_drain("t4");

    // 5. Zero words between packets, then reset mid-packet
    add_packet(2, 4'h6, 8'hC3, 8'h21, 1'b1);
    flush_words();
    send_word(32'h0);
    send_word(32'h0);
    add_packet(1, 4'h9, 8'h7E, 8'h00, 1'b1);
    flush_words();
    wait_drain("t5a");
    add_packet(6, 4'h1, 8'h40, 8'h01, 1'b0);
    pop_word(w);
    send_word(w);
    byte_q.delete();
    cycles(2);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    cycles(1);
    check("t5 rst valid_o", 128'(valid_o), 128'(0));
    check("t5 rst bits", 128'(packet_bits_o), 128'(0));
    check("t5 rst len", 128'(packet_len_o), 128'(0));
    check("t5 rst error_o", 128'(error_o), 128'(0));
    check("t5 rst ready_o", 128'(ready_o), 128'(1));
    add_packet(1, 4'hA, 8'h5C, 8'h00, 1'b1);
    flush_words();
    wait_drain("t5b");
    check("t5 final error_o", 128'(error_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
